mont_final_sub: RTL and testbench

- Downstream stage of the 1024-bit Montgomery multiplier.
- Takes the multiplier's 1025-bit output T (T < 2M) and the modulus M, and produces the fully reduced value R = (T >= M) ? T - M : T, which is 1024 bits.
- Subtraction is limb-serial: LIMB bits per cycle, with the borrow held in a register, so no 1025-bit carry chain is needed.
- Uses the same start/done handshake as the multiplier, so done of the multiplier can drive start of this block directly.

---
 rtl/mont_pkg.sv | 22 ++
 rtl/mont_limb_sub.sv | 23 ++
 rtl/mont_final_sub.sv | 153 +++++++++++++++
 tb/tb_mont_final_sub.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// mont_pkg: shared constants and types for the Montgomery final-subtraction stage.
//   WIDTH  modulus width (T is WIDTH+1 bits)
//   LIMB   bits subtracted per cycle (must divide WIDTH)
//   NL     limb count after zero-extending T and M to NL*LIMB bits (derived)
package mont_pkg;

    localparam int WIDTH = 1024;
    localparam int LIMB  = 64;
    localparam int NL    = WIDTH / LIMB + 1;

    typedef logic [LIMB-1:0] limb_t;

    // CHK is only reached when the range check is compiled in.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SUB  = 3'd1,
        SEL  = 3'd2,
        DONE = 3'd3,
        CHK  = 3'd4
    } state_t;

endpackage

// File: rtl/mont_limb_sub.sv
// mont_limb_sub: combinational LIMB-bit subtract with borrow.
//   a, b   limb operands
//   bin    borrow in
//   diff   a - b - bin modulo 2^LIMB
//   bout   borrow out
module mont_limb_sub #(
    parameter int LIMB = 64
) (
    input  logic [LIMB-1:0] a,
    input  logic [LIMB-1:0] b,
    input  logic            bin,
    output logic [LIMB-1:0] diff,
    output logic            bout
);

    // One extra bit catches the borrow: a negative result wraps above 2^LIMB.
    logic [LIMB:0] d;

    assign d    = {1'b0, a} - {1'b0, b} - {{LIMB{1'b0}}, bin};
    assign diff = d[LIMB-1:0];
    assign bout = d[LIMB];

endmodule

// File: rtl/mont_final_sub.sv
// mont_final_sub: final conditional subtraction after the Montgomery multiplier.
// Produces R = (T >= M) ? T - M : T, truncated to WIDTH bits, one limb per cycle.
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   start      one-cycle request, sampled only in IDLE
//   in_t       T (WIDTH+1 bits), sampled at the start edge
//   in_m       M (WIDTH bits), sampled at the start edge
//   result     reduced value, held until the next done
//   done       one-cycle pulse, result valid from this cycle on
//   busy       high from the cycle after start through the done cycle
//   range_err  R >= M flag (input broke T < 2M); 0 unless the check is built
// Optional feature: define MONT_FSUB_RANGE_CHK_EN to add a second limb-serial
// pass computing R - M, which sets range_err and stretches latency to 2*NL+1.
module mont_final_sub
    import mont_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH:0]   in_t,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             range_err
);

    localparam int            XW   = NL * LIMB;
    localparam int            CW   = $clog2(NL);
    localparam logic [CW-1:0] LAST = CW'(NL - 1);

    state_t          state;
    logic [XW-1:0]   t_reg;
    logic [XW-1:0]   m_reg;
    // Only the low NL-1 difference limbs are kept; the top limb only feeds the borrow.
    logic [WIDTH-1:0] d_reg;
    logic            borrow;
    logic [CW-1:0]   cnt;

    limb_t op_a;
    limb_t diff;
    logic  sub_bin;
    logic  sub_bout;

`ifdef MONT_FSUB_RANGE_CHK_EN
    logic  borrow2;
    limb_t r_limb;

    // R is never materialised: its limbs are picked on the fly from the
    // rotating T and D registers. The top limb of R is zero by truncation.
    assign r_limb  = (cnt == LAST) ? '0 : (borrow ? t_reg[LIMB-1:0] : d_reg[LIMB-1:0]);
    assign op_a    = (state == CHK) ? r_limb : t_reg[LIMB-1:0];
    assign sub_bin = (state == CHK) ? borrow2 : borrow;
`else
    assign op_a      = t_reg[LIMB-1:0];
    assign sub_bin   = borrow;
    assign range_err = 1'b0;
`endif

    mont_limb_sub #(.LIMB(LIMB)) u_limb_sub (
        .a    (op_a),
        .b    (m_reg[LIMB-1:0]),
        .bin  (sub_bin),
        .diff (diff),
        .bout (sub_bout)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            t_reg   <= '0;
            m_reg   <= '0;
            d_reg   <= '0;
            borrow  <= 1'b0;
            cnt     <= '0;
            result  <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
`ifdef MONT_FSUB_RANGE_CHK_EN
            borrow2   <= 1'b0;
            range_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        t_reg  <= XW'(in_t);
                        m_reg  <= XW'(in_m);
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SUB;
`ifdef MONT_FSUB_RANGE_CHK_EN
                        borrow2   <= 1'b0;
                        range_err <= 1'b0;
`endif
                    end
                end
                SUB: begin
                    borrow <= sub_bout;
                    // T rotates so the original value is back in place for SEL/CHK.
                    t_reg  <= {t_reg[LIMB-1:0], t_reg[XW-1:LIMB]};
`ifdef MONT_FSUB_RANGE_CHK_EN
                    // M is needed again by the check pass.
                    m_reg  <= {m_reg[LIMB-1:0], m_reg[XW-1:LIMB]};
`else
                    m_reg  <= {{LIMB{1'b0}}, m_reg[XW-1:LIMB]};
`endif
                    if (cnt != LAST) begin
                        d_reg <= {diff, d_reg[WIDTH-1:LIMB]};
                        cnt   <= cnt + 1'b1;
                    end else begin
                        cnt   <= '0;
`ifdef MONT_FSUB_RANGE_CHK_EN
                        state <= CHK;
`else
                        state <= SEL;
`endif
                    end
                end
`ifdef MONT_FSUB_RANGE_CHK_EN
                CHK: begin
                    borrow2 <= sub_bout;
                    t_reg   <= {t_reg[LIMB-1:0], t_reg[XW-1:LIMB]};
                    m_reg   <= {m_reg[LIMB-1:0], m_reg[XW-1:LIMB]};
                    if (cnt != LAST) begin
                        d_reg <= {d_reg[LIMB-1:0], d_reg[WIDTH-1:LIMB]};
                        cnt   <= cnt + 1'b1;
                    end else begin
                        cnt   <= '0;
                        state <= SEL;
                    end
                end
`endif
                SEL: begin
                    result <= borrow ? t_reg[WIDTH-1:0] : d_reg;
                    done   <= 1'b1;
                    state  <= DONE;
`ifdef MONT_FSUB_RANGE_CHK_EN
                    range_err <= ~borrow2;
`endif
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_final_sub.sv
// tb_mont_final_sub: randomized + directed bench for mont_final_sub with a
// latency-level reference model compared against the outputs every cycle.
// Honours MONT_FSUB_RANGE_CHK_EN for latency and range_err expectations.
module tb_mont_final_sub;
    import mont_pkg::*;

`ifdef MONT_FSUB_RANGE_CHK_EN
    localparam int LAT  = 2 * NL + 1;
    localparam bit FEAT = 1'b1;
`else
    localparam int LAT  = NL + 1;
    localparam bit FEAT = 1'b0;
`endif
    localparam int HOLD = (2 * LAT + 5 > 40) ? 2 * LAT + 5 : 40;

    logic             clk    = 1'b0;
    logic             resetn = 1'b0;
    logic             start  = 1'b0;
    logic [WIDTH:0]   in_t   = '0;
    logic [WIDTH-1:0] in_m   = '0;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;
    logic             range_err;

    int tests  = 0;
    int fails  = 0;
    int n_done = 0;
    bit chk_en = 1'b0;

    mont_final_sub dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .in_t      (in_t),
        .in_m      (in_m),
        .result    (result),
        .done      (done),
        .busy      (busy),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference arithmetic ----------------
    function automatic logic [WIDTH-1:0] ref_r(input logic [WIDTH:0] t, input logic [WIDTH-1:0] m);
        logic [WIDTH:0] me;
        logic [WIDTH:0] df;
        me = {1'b0, m};
        df = t - me;
        if (t >= me) return df[WIDTH-1:0];
        return t[WIDTH-1:0];
    endfunction

    function automatic logic ref_e(input logic [WIDTH:0] t, input logic [WIDTH-1:0] m);
        return FEAT && (ref_r(t, m) >= m);
    endfunction

    function automatic logic [WIDTH:0] rnd_wide();
        logic [WIDTH:0] v;
        logic [WIDTH:0] w;
        v = '0;
        for (int i = 0; i < WIDTH / 32 + 1; i++) begin
            w       = '0;
            w[31:0] = $urandom;
            v       = (v << 32) | w;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got ..%h want ..%h (low 64 bits; upper bits %s) at %0t",
                     name, act[63:0], exp[63:0],
                     (act[WIDTH-1:64] === exp[WIDTH-1:64]) ? "equal" : "differ", $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Accepts a start only when not busy; done/result appear LAT edges later,
    // busy drops one edge after done.
    logic             m_busy, m_done, m_rerr, m_pend_e;
    logic [WIDTH-1:0] m_res, m_pend_r;
    int               m_cnt;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_busy = 1'b0; m_done = 1'b0; m_rerr = 1'b0; m_res = '0; m_cnt = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy   = 1'b1;
                m_cnt    = 0;
                m_rerr   = 1'b0;
                m_pend_r = ref_r(in_t, in_m);
                m_pend_e = ref_e(in_t, in_m);
            end
        end else begin
            m_cnt++;
            if (m_cnt == LAT) begin
                m_done = 1'b1; m_res = m_pend_r; m_rerr = m_pend_e;
            end else if (m_cnt == LAT + 1) begin
                m_done = 1'b0; m_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_done",   done,      m_done);
            check("cyc_busy",   busy,      m_busy);
            check("cyc_result", result,    m_res);
            check("cyc_rerr",   range_err, m_rerr);
        end
        if (done) n_done++;
    end

    // ---------------- directed helper ----------------
    // Called at a negedge with the DUT idle; returns at a negedge with it idle.
    task automatic do_op(input string name, input logic [WIDTH:0] t, input logic [WIDTH-1:0] m,
                         input logic [WIDTH-1:0] exp_r, input logic exp_e);
        int n;
        n     = 0;
        start = 1'b1; in_t = t; in_m = m;
        @(negedge clk);
        start = 1'b0;
        in_t  = '1; in_m = '1;   // operands must already be captured
        while (!done && n < 4 * LAT) begin
            @(negedge clk);
            n++;
        end
        check({name, "_lat"},  n,         LAT);
        check({name, "_res"},  result,    exp_r);
        check({name, "_rerr"}, range_err, exp_e);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [WIDTH:0]   t;
        logic [WIDTH:0]   two_m;
        logic [WIDTH-1:0] m;
        int d1, d2, nd, n0, k;

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_result", result, '0);
        check("rst_done",   done,   '0);
        check("rst_busy",   busy,   '0);
        check("rst_rerr",   range_err, '0);
        #2 resetn = 1'b1;
        @(negedge clk);

        // T = 2^W + 4, M = 2^W - 1 -> 5
        t = '0; t[WIDTH] = 1'b1; t[2] = 1'b1;
        m = '1;
        do_op("top_bit", t, m, WIDTH'(5), 1'b0);
        do_op("t_lt_m", (WIDTH+1)'(3), WIDTH'(7), WIDTH'(3), 1'b0);
        m = {(WIDTH/8){8'hA5}};
        do_op("t_eq_m", {1'b0, m}, m, '0, 1'b0);
        // borrow ripples through every limb
        t = '0; t[WIDTH] = 1'b1;
        do_op("ripple", t, WIDTH'(1), '1, FEAT);
        t = rnd_wide(); t[WIDTH] = 1'b0;
        do_op("m_zero", t, '0, t[WIDTH-1:0], FEAT);
        do_op("chk_hi", (WIDTH+1)'(20), WIDTH'(7), WIDTH'(13), FEAT);
        do_op("chk_lo", (WIDTH+1)'(9),  WIDTH'(7), WIDTH'(2),  1'b0);

        // start held high: DONE-cycle start ignored, next accepted one cycle later
        d1 = -1; d2 = -1; nd = 0;
        start = 1'b1; in_t = (WIDTH+1)'(10); in_m = WIDTH'(3);
        for (k = 1; k <= HOLD; k++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                if (nd == 1) d1 = k; else if (nd == 2) d2 = k;
                check("held_res", result, WIDTH'(7));
            end
        end
        start = 1'b0;
        check("held_ndone", nd, 2);
        check("held_first", d1, LAT + 1);
        check("held_gap",   d2 - d1, LAT + 2);
        k = 0;
        while (busy && k < 4 * LAT) begin @(negedge clk); k++; end
        check("held_drain", busy, 1'b0);
        @(negedge clk);

        // reset during SUB aborts the operation
        start = 1'b1; in_t = rnd_wide() >> 1; in_m = '1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        @(negedge clk);
        #2 resetn = 1'b1;
        n0 = n_done;
        repeat (3 * LAT) @(negedge clk);
        check("abort_nodone", n_done - n0, 0);
        check("abort_result", result, '0);
        check("abort_busy",   busy,   1'b0);
        do_op("after_abort", (WIDTH+1)'(10), WIDTH'(3), WIDTH'(7), FEAT);

        // randomized traffic, including starts while busy and in the DONE cycle
        n0 = n_done;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 7))
                    0:       m = WIDTH'($urandom_range(0, 15));
                    1:       m = '0;
                    2:       m = '1;
                    default: m = rnd_wide()[WIDTH-1:0];
                endcase
                two_m = {m, 1'b0};
                case ($urandom_range(0, 7))
                    0:       t = {1'b0, m};
                    1:       t = {1'b0, m} - 1'b1;
                    2:       t = rnd_wide();                 // may break T < 2M
                    default: t = (m == '0) ? (rnd_wide() >> 1) : rnd_wide() % two_m;
                endcase
                in_t = t; in_m = m;
            end
        end
        start = 1'b0;
        k = 0;
        while (busy && k < 4 * LAT) begin @(negedge clk); k++; end
        @(negedge clk);
        check("rand_activity", (n_done - n0) > 50, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
